ex_flush_ctrl: RTL

- Exception/interrupt sequencer for the 5-stage MIPS pipeline. Sits beside the WB stage and the CP0 block.
- Decides at WB commit whether to take an interrupt, a synchronous exception or an ERET.
- Sequences the pipeline-wide flush, then hands a redirect PC to the fetch stage with a valid/ready handshake.
- Tells CP0 when an interrupt is taken, so CP0 records EPC/Cause for it.

---
 rtl/ex_flush_ctrl_if.sv | 51 +++++
 rtl/ex_flush_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ex_flush_ctrl_if.sv
// rtl/ex_flush_ctrl_if.sv - WB/CP0/fetch signal bundle for ex_flush_ctrl (timer ports under CP0_TIMER_EN)
interface ex_flush_ctrl_if;
    // WB commit information
    logic        ws_valid;
    logic        ws_ex;
    logic        ws_eret;
    logic [31:0] ws_pc;
    logic        ws_slot;
    // CP0 state
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    // fetch redirect handshake and pipeline flush
    logic        fs_ready;
    logic        ex_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    // interrupt record towards CP0
    logic        int_take;
    logic [31:0] int_epc;
    logic        int_bd;
    logic        busy;
`ifdef CP0_TIMER_EN
    logic [31:0] timer_compare;
    logic        timer_irq;
`endif

    // pipeline/CP0 side: drives commit info, observes the sequencer
    modport master (
        output ws_valid, ws_ex, ws_eret, ws_pc, ws_slot,
        output cp0_status, cp0_cause, cp0_epc, fs_ready,
        input  ex_flush, redirect_valid, redirect_pc,
        input  int_take, int_epc, int_bd, busy
`ifdef CP0_TIMER_EN
        , output timer_compare
        , input  timer_irq
`endif
    );

    // sequencer side
    modport slave (
        input  ws_valid, ws_ex, ws_eret, ws_pc, ws_slot,
        input  cp0_status, cp0_cause, cp0_epc, fs_ready,
        output ex_flush, redirect_valid, redirect_pc,
        output int_take, int_epc, int_bd, busy
`ifdef CP0_TIMER_EN
        , input  timer_compare
        , output timer_irq
`endif
    );
endinterface

// File: rtl/ex_flush_ctrl.sv
// rtl/ex_flush_ctrl.sv - WB-commit exception/interrupt/ERET flush and redirect sequencer (optional CP0_TIMER_EN)
module ex_flush_ctrl #(
    parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic           clk,
    input logic           reset,
    ex_flush_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;

    logic        ex_flush_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        int_take_w;
    logic [31:0] int_epc_w;
    logic        int_bd_w;

    logic [7:0]  ip_w;
    logic        int_pending;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic        toggle_q;
    logic        timer_irq_q;
    logic [31:0] compare_q;

    // free-running count at half clock rate; irq latches on match and
    // is dropped only when software rewrites the compare value
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 32'd0;
            toggle_q    <= 1'b0;
            timer_irq_q <= 1'b0;
            compare_q   <= 32'd0;
        end else begin
            toggle_q  <= ~toggle_q;
            if (toggle_q) begin
                count_q <= count_q + 32'd1;
            end
            compare_q <= bus.timer_compare;
            if (bus.timer_compare != compare_q) begin
                timer_irq_q <= 1'b0;
            end else if (count_q == bus.timer_compare) begin
                timer_irq_q <= 1'b1;
            end
        end
    end

    assign bus.timer_irq = timer_irq_q;
    assign ip_w = {bus.cp0_cause[15] | timer_irq_q, bus.cp0_cause[14:8]};
`else
    assign ip_w = bus.cp0_cause[15:8];
`endif

    assign int_pending = bus.cp0_status[0] & ~bus.cp0_status[1]
                       & (|(ip_w & bus.cp0_status[15:8]));

    // state, flush counter and latched redirect target
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // event arbitration at commit, flush countdown, redirect handshake
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        target_d         = target_q;
        ex_flush_w       = 1'b0;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 32'd0;
        int_take_w       = 1'b0;
        int_epc_w        = 32'd0;
        int_bd_w         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // an interrupt only lands on an instruction boundary, and
                // it shadows any exception/ERET carried by that instruction
                if (bus.ws_valid && (int_pending || bus.ws_ex || bus.ws_eret)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                    if (int_pending) begin
                        target_d   = EX_ENTRY;
                        int_take_w = 1'b1;
                        int_epc_w  = bus.ws_slot ? (bus.ws_pc - 32'd4) : bus.ws_pc;
                        int_bd_w   = bus.ws_slot;
                    end else if (bus.ws_ex) begin
                        target_d = EX_ENTRY;
                    end else begin
                        target_d = bus.cp0_epc;
                    end
                end
            end
            ST_FLUSH: begin
                ex_flush_w = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                redirect_valid_w = 1'b1;
                redirect_pc_w    = target_q;
                if (bus.fs_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // a reset cycle must never tell CP0 an interrupt was taken
        if (reset) begin
            int_take_w = 1'b0;
            int_epc_w  = 32'd0;
            int_bd_w   = 1'b0;
        end
    end

    assign bus.ex_flush       = ex_flush_w;
    assign bus.redirect_valid = redirect_valid_w;
    assign bus.redirect_pc    = redirect_pc_w;
    assign bus.int_take       = int_take_w;
    assign bus.int_epc        = int_epc_w;
    assign bus.int_bd         = int_bd_w;
    assign bus.busy           = (state_q != ST_IDLE);

endmodule
